// File: rtl/queen_stack_checker.sv
// queen_stack_checker: LIFO board store with a one-entry-per-cycle conflict scan; define DIAG_CHECK_EN for diagonal (queen) checks, otherwise column-only
module queen_stack_checker #(
    parameter int N  = 8,
    parameter int W  = 3,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  col_in,
    input  logic          start,
    input  logic [W-1:0]  cand_col,
    output logic          busy,
    output logic          done,
    output logic          safe,
    output logic [DW-1:0] depth,
    output logic          full,
    output logic          empty,
    output logic          err
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t state, state_nx;
    logic [W-1:0] entry [N];
    logic [W-1:0] cand, cur;
    logic [DW-1:0] idx, top;
    logic col_eq, conflict, last, op_ok, bad, busy_nx, done_nx, safe_nx;
    assign full  = depth == DW'(N);
    assign empty = depth == '0;
    assign top   = depth - DW'(1);
    assign cur   = entry[idx[W-1:0]];
    assign col_eq = cur == cand;
    assign last  = idx + DW'(1) == depth;
    assign op_ok = state == IDLE && !start;
    assign bad   = (start && state != IDLE) || ((push || pop) && (state != IDLE || start)) ||
                   (op_ok && ((push && !pop && full) || (pop && empty)));
`ifdef DIAG_CHECK_EN
    logic [W:0] diff, absd;
    logic [DW-1:0] dist;
    assign diff = {1'b0, cur} - {1'b0, cand};
    assign absd = diff[W] ? ({1'b0, cand} - {1'b0, cur}) : diff;
    assign dist = depth - idx;
    assign conflict = col_eq || (32'(absd) == 32'(dist));
`else
    assign conflict = col_eq;
`endif
    // FSM and registered handshake outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            safe  <= 1'b0;
            cand  <= '0;
            idx   <= '0;
        end else begin
            state <= state_nx;
            busy  <= busy_nx;
            done  <= done_nx;
            safe  <= safe_nx;
            cand  <= (state == IDLE && start) ? cand_col : cand;
            idx   <= (state == IDLE) ? '0 : (state == SCAN) ? idx + DW'(1) : idx;
        end
    end
    // Next state: empty/full boards resolve without scanning
    always_comb begin
        state_nx = state == IDLE ? (start ? ((empty || full) ? DONE : SCAN) : IDLE) :
                   state == SCAN ? ((conflict || last) ? DONE : SCAN) : IDLE;
    end
    // Next values of the registered outputs
    always_comb begin
        busy_nx = state_nx != IDLE;
        done_nx = state_nx == DONE;
        safe_nx = (state == IDLE && start) ? empty :
                  (state == SCAN) ? (conflict ? 1'b0 : last ? 1'b1 : safe) : safe;
    end
    // Stack: push, pop, or replace top; only while idle and not starting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            depth <= '0;
            for (int i = 0; i < N; i++) entry[i] <= '0;
        end else if (op_ok) begin
            if (push && pop && !empty) entry[top[W-1:0]] <= col_in;
            else if (push && !pop && !full) begin
                entry[depth[W-1:0]] <= col_in;
                depth <= depth + DW'(1);
            end else if (pop && !push && !empty) depth <= top;
        end
    end
    // Sticky protocol error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err <= 1'b0;
        else if (bad) err <= 1'b1;
    end
endmodule

// File: tb/tb_queen_stack_checker.sv
// tb_queen_stack_checker: scoreboard bench for queen_stack_checker; expectations cover both DIAG_CHECK_EN settings
module tb_queen_stack_checker;
`ifdef DIAG_CHECK_EN
    localparam bit DIAG = 1'b1;
`else
    localparam bit DIAG = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1, push = 1'b0, pop = 1'b0, start = 1'b0;
    logic [2:0] col_in = '0, cand_col = '0;
    logic busy, done, safe, full, empty, err;
    logic [3:0] depth;
    int cyc = 0, checks = 0, errors = 0;
    typedef struct { logic s; int c; } exp_t;
    exp_t exp_q[$];

    queen_stack_checker dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .col_in(col_in),
        .start(start), .cand_col(cand_col), .busy(busy), .done(done), .safe(safe),
        .depth(depth), .full(full), .empty(empty), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Monitor: every done pulse pops one expectation (safe value and cycle)
    always @(posedge clk) begin
        #1;
        if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, none required", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (safe !== e.s || cyc != e.c) begin
                    errors++;
                    $display("FAIL done_result: safe=%0b cycle=%0d, required safe=%0b cycle=%0d", safe, cyc, e.s, e.c);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, expv);
        end
    endtask

    task automatic op(input logic p, input logic q, input logic [2:0] c);
        push = p; pop = q; col_in = c;
        @(negedge clk);
        push = 1'b0; pop = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            if (!busy) return;
            @(negedge clk);
        end
        chk("busy_timeout", 32'(busy), 0);
    endtask

    task automatic do_start(input logic [2:0] c, input logic s, input int lat);
        exp_q.push_back('{s, cyc + lat});
        start = 1'b1; cand_col = c;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_safe", 32'(safe), 0);
        chk("rst_depth", 32'(depth), 0);
        chk("rst_err", 32'(err), 0);
        reset = 1'b0;
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        // 1: empty board is always safe, done next cycle
        do_start(3'd5, 1'b1, 1);
        chk("t1_depth", 32'(depth), 0);
        chk("t1_empty", 32'(empty), 1);
        // 2: single queen in column 0
        op(1, 0, 3'd0);
        chk("t2_depth", 32'(depth), 1);
        do_start(3'd0, 1'b0, 2);
        do_start(3'd1, !DIAG, 2);
        do_start(3'd2, 1'b1, 2);
        // 3: stack 0,4,7,5; cand 7 hits row1 diagonal (queen) or row2 column (rook)
        op(1, 0, 3'd4);
        op(1, 0, 3'd7);
        op(1, 0, 3'd5);
        chk("t3_depth", 32'(depth), 4);
        do_start(3'd2, 1'b1, 5);
        do_start(3'd7, 1'b0, DIAG ? 3 : 4);
        chk("t3_err", 32'(err), 0);
        // push while busy and start while busy: scan unaffected, err set
        exp_q.push_back('{1'b1, cyc + 5});
        start = 1'b1; cand_col = 3'd2;
        @(negedge clk);
        start = 1'b0; push = 1'b1; col_in = 3'd3;
        @(negedge clk);
        push = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        chk("busy_op_err", 32'(err), 1);
        chk("busy_op_depth", 32'(depth), 4);
        do_reset();
        chk("reset_clears_err", 32'(err), 0);
        // start and push in the same cycle: start wins, push rejected
        op(1, 0, 3'd0);
        exp_q.push_back('{1'b1, cyc + 2});
        start = 1'b1; cand_col = 3'd2; push = 1'b1; col_in = 3'd3;
        @(negedge clk);
        start = 1'b0; push = 1'b0;
        wait_idle();
        chk("start_push_depth", 32'(depth), 1);
        chk("start_push_err", 32'(err), 1);
        do_reset();
        // 4: replace top, then pop to empty and underflow
        op(1, 0, 3'd0);
        op(1, 0, 3'd4);
        op(1, 1, 3'd6);
        chk("t4_replace_depth", 32'(depth), 2);
        do_start(3'd6, 1'b0, 3);
        op(0, 1, 3'd0);
        op(0, 1, 3'd0);
        chk("t4_empty", 32'(empty), 1);
        chk("t4_err_clean", 32'(err), 0);
        op(0, 1, 3'd0);
        chk("t4_underflow_err", 32'(err), 1);
        chk("t4_underflow_depth", 32'(depth), 0);
        do_reset();
        // 5: full board, overflow, start on full
        op(1, 0, 3'd0); op(1, 0, 3'd4); op(1, 0, 3'd7); op(1, 0, 3'd5);
        op(1, 0, 3'd2); op(1, 0, 3'd6); op(1, 0, 3'd1); op(1, 0, 3'd3);
        chk("t5_full", 32'(full), 1);
        chk("t5_depth", 32'(depth), 8);
        op(1, 0, 3'd3);
        chk("t5_overflow_err", 32'(err), 1);
        chk("t5_overflow_depth", 32'(depth), 8);
        do_start(3'd3, 1'b0, 1);
        do_reset();
        // 6: reset mid-scan aborts with no done
        op(1, 0, 3'd0); op(1, 0, 3'd4); op(1, 0, 3'd7); op(1, 0, 3'd5);
        start = 1'b1; cand_col = 3'd2;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("t6_scanning", 32'(busy), 1);
        reset = 1'b1;
        #1;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_done", 32'(done), 0);
        chk("t6_depth", 32'(depth), 0);
        chk("t6_err", 32'(err), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("t6_idle", 32'(busy), 0);
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
